// File: rtl/br_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: in-flight branch record and predictor update beat.
package br_resolve_queue_pkg;

  localparam int DEFAULT_IDX_W = 32;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [DEFAULT_IDX_W-1:0] idx;
    logic                     pred;
  } inflight_t;

  typedef struct packed {
    logic                     en;
    logic                     taken;
    logic                     correct;
    logic [DEFAULT_IDX_W-1:0] idx;
  } bp_update_t;

endpackage

// File: rtl/br_resolve_queue_if.sv
// Fetch/resolve stimulus side and predictor update side of the branch resolve queue.
interface br_resolve_queue_if #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             fetch_valid_i;
  logic [IDX_W-1:0] fetch_idx_i;
  logic             pred_i;
  logic             fetch_ready_o;
  logic             resolve_valid_i;
  logic             resolve_taken_i;
  logic             flush_i;
  logic [IDX_W-1:0] idx_o;
  logic             update_en_o;
  logic             br_result_o;
  logic             correct_o;
  logic             mispredict_o;
  logic [CNT_W-1:0] count_o;
  logic             err_o;

  modport master (
    output fetch_valid_i, fetch_idx_i, pred_i, resolve_valid_i, resolve_taken_i, flush_i,
    input  fetch_ready_o, idx_o, update_en_o, br_result_o, correct_o, mispredict_o,
           count_o, err_o
  );

  modport slave (
    input  fetch_valid_i, fetch_idx_i, pred_i, resolve_valid_i, resolve_taken_i, flush_i,
    output fetch_ready_o, idx_o, update_en_o, br_result_o, correct_o, mispredict_o,
           count_o, err_o
  );

endinterface

// File: rtl/br_resolve_queue_fifo.sv
// In-order storage for in-flight branches; callers pre-qualify push/pop against full/empty.
module br_resolve_queue_fifo
  import br_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  inflight_t                  wr_data_i,
  output inflight_t                  rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  inflight_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap naturally since DEPTH is a power of two; occupancy lives in its own register.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr];
  assign count_o   = count;
  assign full_o    = (count == CNT_W'(DEPTH));
  assign empty_o   = (count == '0);

endmodule

// File: rtl/br_resolve_queue.sv
// Holds fetched branches until they resolve, then issues one registered update beat to the predictor.
module br_resolve_queue
  import br_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input logic               clk_i,
  input logic               rst_i,
  br_resolve_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  inflight_t        wr_entry;
  inflight_t        rd_entry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  bp_update_t       upd;
  logic             err;

  // Flush kills both sides of the handshake in the same cycle; nothing bypasses an empty queue.
  assign push = bus.fetch_valid_i & ~full & ~bus.flush_i;
  assign pop  = bus.resolve_valid_i & ~empty & ~bus.flush_i;

  assign wr_entry.idx  = bus.fetch_idx_i;
  assign wr_entry.pred = bus.pred_i;

  br_resolve_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (bus.flush_i),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (wr_entry),
    .rd_data_o (rd_entry),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Beat payload is held between pops so the predictor sees stable idx/result lines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd <= '0;
      err <= 1'b0;
    end else begin
      upd.en <= pop;
      if (pop) begin
        upd.idx     <= rd_entry.idx;
        upd.taken   <= bus.resolve_taken_i;
        upd.correct <= (rd_entry.pred == bus.resolve_taken_i);
      end
      if (bus.resolve_valid_i && empty) err <= 1'b1;
    end
  end

  assign bus.fetch_ready_o = ~full;
  assign bus.count_o       = count;
  assign bus.update_en_o   = upd.en;
  assign bus.idx_o         = upd.idx;
  assign bus.br_result_o   = upd.taken;
  assign bus.correct_o     = upd.correct;
  assign bus.mispredict_o  = upd.en & ~upd.correct;
  assign bus.err_o         = err;

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed vector table, corner-case sequences and random traffic against a queue-based reference.
module tb_br_resolve_queue;

  localparam int DEPTH = 8;
  localparam int IDX_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  br_resolve_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  br_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } ent_t;

  ent_t             mq[$];
  logic             m_en  = 1'b0;
  logic [IDX_W-1:0] m_idx = '0;
  logic             m_res = 1'b0;
  logic             m_cor = 1'b0;
  logic             m_err = 1'b0;

  typedef struct {
    logic             r, fv;
    logic [IDX_W-1:0] fi;
    logic             p, rv, rt, fl;
    logic             e_en;
    logic [IDX_W-1:0] e_idx;
    logic             e_res, e_cor, e_mis;
    logic [3:0]       e_cnt;
    logic             e_rdy, e_err;
  } vec_t;

  vec_t tbl[13];

  // Drives one cycle of stimulus, advances the reference from the queue rules, then waits past the edge.
  task automatic applyStimulus(input logic r, input logic fv, input logic [IDX_W-1:0] fi,
                               input logic p, input logic rv, input logic rt, input logic fl);
    int   sz;
    ent_t e;
    rst                 = r;
    bus.fetch_valid_i   = fv;
    bus.fetch_idx_i     = fi;
    bus.pred_i          = p;
    bus.resolve_valid_i = rv;
    bus.resolve_taken_i = rt;
    bus.flush_i         = fl;
    if (r) begin
      mq.delete();
      m_en = 0; m_idx = '0; m_res = 0; m_cor = 0; m_err = 0;
    end else begin
      sz = mq.size();
      if (rv && sz == 0) m_err = 1;
      m_en = 0;
      if (fl) begin
        mq.delete();
      end else begin
        if (rv && sz > 0) begin
          e = mq.pop_front();
          m_en = 1; m_idx = e.idx; m_res = rt; m_cor = (e.pred == rt);
        end
        if (fv && sz < DEPTH) begin
          e.idx = fi; e.pred = p;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_en, input logic [IDX_W-1:0] e_idx,
                             input logic e_res, input logic e_cor, input logic e_mis,
                             input logic [3:0] e_cnt, input logic e_rdy, input logic e_err);
    vectors++;
    if ({bus.update_en_o, bus.idx_o, bus.br_result_o, bus.correct_o, bus.mispredict_o,
         bus.count_o, bus.fetch_ready_o, bus.err_o} !==
        {e_en, e_idx, e_res, e_cor, e_mis, e_cnt, e_rdy, e_err}) begin
      miscompares++;
      $display("[TB] FAIL %s: got en=%0b idx=%h res=%0b cor=%0b mis=%0b cnt=%0d rdy=%0b err=%0b, want en=%0b idx=%h res=%0b cor=%0b mis=%0b cnt=%0d rdy=%0b err=%0b",
               name, bus.update_en_o, bus.idx_o, bus.br_result_o, bus.correct_o, bus.mispredict_o,
               bus.count_o, bus.fetch_ready_o, bus.err_o,
               e_en, e_idx, e_res, e_cor, e_mis, e_cnt, e_rdy, e_err);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_en, m_idx, m_res, m_cor, m_en & ~m_cor, 4'(mq.size()),
                mq.size() < DEPTH, m_err);
  endtask

  task automatic step(input string name, input logic r, input logic fv, input logic [IDX_W-1:0] fi,
                      input logic p, input logic rv, input logic rt, input logic fl);
    applyStimulus(r, fv, fi, p, rv, rt, fl);
    checkModel(name);
  endtask

  initial begin
    bus.fetch_valid_i   = 0;
    bus.fetch_idx_i     = '0;
    bus.pred_i          = 0;
    bus.resolve_valid_i = 0;
    bus.resolve_taken_i = 0;
    bus.flush_i         = 0;

    //         r  fv fi     p  rv rt fl  en idx    res cor mis cnt rdy err
    tbl[0]  = '{1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 32'h10, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 1, 32'h20, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 2, 1, 0};
    tbl[3]  = '{0, 1, 32'h30, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 3, 1, 0};
    tbl[4]  = '{0, 0, 32'h0,  0, 1, 1, 0, 1, 32'h10, 1, 1, 0, 2, 1, 0};
    tbl[5]  = '{0, 0, 32'h0,  0, 1, 1, 0, 1, 32'h20, 1, 0, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 32'h0,  0, 1, 0, 0, 1, 32'h30, 0, 0, 1, 0, 1, 0};
    tbl[7]  = '{0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h30, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 32'h0,  0, 1, 1, 0, 0, 32'h30, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h30, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 1, 32'h40, 0, 1, 0, 0, 0, 32'h30, 0, 0, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 32'h0,  0, 1, 0, 0, 1, 32'h40, 0, 1, 0, 0, 1, 1};
    tbl[12] = '{1, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].r, tbl[i].fv, tbl[i].fi, tbl[i].p, tbl[i].rv, tbl[i].rt, tbl[i].fl);
      checkOutput($sformatf("table[%0d]", i), tbl[i].e_en, tbl[i].e_idx, tbl[i].e_res,
                  tbl[i].e_cor, tbl[i].e_mis, tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_err);
    end

    // Fill to capacity, attempt an overflow push, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step("fill", 0, 1, 32'h100 + i, i[0], 0, 0, 0);
    step("overflow_push", 0, 1, 32'h999, 1, 0, 0, 0);
    checkOutput("full_state", 0, '0, 0, 0, 0, 4'(DEPTH), 0, 0);
    step("full_push_pop", 0, 1, 32'h999, 1, 1, 1, 0);
    step("pop_after_full", 0, 0, '0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH - 2; i++)
      step("drain", 0, 0, '0, 0, 1, i[1], 0);

    // Back-to-back push/pop pairs wrap both pointers with constant occupancy.
    for (int i = 0; i < 3; i++)
      step("prewrap", 0, 1, 32'h200 + i, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("wrap_pair", 0, 1, 32'h300 + i, i[0], 1, i[1], 0);

    // Flush with concurrent push and resolve drops everything; next resolve hits an empty queue.
    step("flush_idle", 0, 0, '0, 0, 0, 0, 0);
    step("flush_hit", 0, 1, 32'h400, 1, 1, 1, 1);
    step("after_flush_resolve", 0, 0, '0, 0, 1, 0, 0);
    step("err_sticky", 0, 0, '0, 0, 0, 0, 0);

    // Reset lands while entries are queued and a pop is in flight.
    step("rst_clear", 1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("rst_fill", 0, 1, 32'h500 + i, 0, 0, 0, 0);
    step("rst_pop", 0, 0, '0, 0, 1, 1, 0);
    step("rst_during_pop", 1, 0, '0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("rst_refill", 0, 1, 32'h600 + i, 1, 0, 0, 0);
    step("rst_with_pop", 1, 0, '0, 0, 1, 0, 0);
    step("post_rst_idle", 0, 0, '0, 0, 0, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      logic r, fl, fv, rv;
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 29) == 0);
      fv = ($urandom_range(0, 99) < ((i % 200) < 100 ? 70 : 35));
      rv = ($urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 70));
      step("random", r, fv, $urandom, 1'($urandom), rv, 1'($urandom), fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
